xor_share_arbiter: RTL and testbench
====================================

# xor_share_arbiter

Shares a single registered WIDTH-bit XOR unit among N requesters. Arbitration is round-robin, and each side uses a valid/ready handshake. The block sits between the requester-side datapath blocks and the single shared XOR resource. It returns each result tagged with the index of the requester that issued it.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- IDW, $clog2(N), requester-index width

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  request i valid
- req_x  input  N*WIDTH  operand x, requester i in bits [i*WIDTH +: WIDTH]
- req_y  input  N*WIDTH  operand y, same packing
- req_ready  output  N  one-hot grant; request i accepted when req_valid[i] & req_ready[i]
- rsp_valid  output  1  result held in output register
- rsp_z  output  WIDTH  x ^ y of the accepted request
- rsp_id  output  IDW  index of the requester that owns rsp_z
- rsp_ready  input  1  consumer accepts the result when rsp_valid & rsp_ready

## Operation
- State machine has two states:
  - IDLE: output register is empty.
  - HOLD: output register is full, rsp_valid=1.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Grant selection:
  - Search starts at ptr and proceeds ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i]=1 only when can_accept and i is the granted index, so at most one bit is set.
  - req_ready is combinational from req_valid, state and rsp_ready.
  - Requesters must not derive req_valid from req_ready.
- On accept of index g:
  - rsp_z <= x[g] ^ y[g]
  - rsp_id <= g
  - rsp_valid <= 1
  - state <= HOLD
  - ptr <= (g+1) mod N, wrapping from N-1 to 0.
- In HOLD with rsp_ready=1 and no valid request: rsp_valid <= 0, state <= IDLE. rsp_z and rsp_id keep their last values.
- In HOLD with rsp_ready=0:
  - All outputs are frozen and req_ready=0.
  - Requesters keep valid and data stable until they are granted.
- Simultaneous events: a HOLD cycle with rsp_ready=1 and a pending request does a drain and a refill in the same edge. The new result replaces the old one and rsp_valid stays 1.
- ptr advances only on an accepted request, never on idle cycles.
- Reset, asynchronous on rst_n low, including mid-transfer:
  - state=IDLE, ptr=0
  - rsp_valid=0, rsp_z=0, rsp_id=0
  - req_ready=0 while rst_n=0
  - Any held result is discarded.

## Timing
- Latency: a request accepted at edge k gives rsp_valid=1 with its result from edge k to k+1 onward.
- Throughput: one result per cycle when rsp_ready is held at 1.
- Fairness: a continuously valid requester is granted within N accepts.
- Every output except req_ready is a flop.
- Combinational paths into req_ready: req_valid → req_ready and rsp_ready → req_ready. There is no combinational path from req_x/req_y to any output.

## Structure
- Package xor_share_pkg:
  - state enum {S_IDLE, S_HOLD}
  - default constants N_DEF=4, WIDTH_DEF=8
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr, en
  - outputs: one-hot gnt[N], gnt_idx, any
  - purely combinational
- The top level holds the FSM, ptr, the output register, and the operand mux plus XOR.

## Test plan
- Reset, single request:
  - Hold rst_n=0: all outputs are 0.
  - Release, then drive req_valid=0001, x0=8'hA5, y0=8'h0F, rsp_ready=1.
  - Expect req_ready=0001 in the same cycle, then rsp_valid=1, rsp_z=8'hAA, rsp_id=0 one cycle later.
- Round-robin, all valid:
  - req_valid=1111 with rsp_ready=1 for 8 cycles.
  - Grant sequence is 0,1,2,3,0,1,2,3 and rsp_id follows one cycle later.
  - rsp_valid stays 1 with no bubbles.
- Backpressure:
  - Accept id 2 (x=8'hFF, y=8'h01), then hold rsp_ready=0 for 3 cycles.
  - rsp_z=8'hFE and rsp_id=2 are stable, and req_ready=0000 throughout.
  - Raising rsp_ready accepts the next request in that same cycle.
- Wrap and skip:
  - With ptr=3 and req_valid=0110, id 1 is granted first and ptr becomes 2.
  - Id 2 is granted next and ptr becomes 3.
- Drain to idle:
  - HOLD with rsp_ready=1 and req_valid=0000.
  - Next cycle rsp_valid=0 and rsp_z keeps its last value.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously while in HOLD with rsp_ready=0.
  - rsp_valid drops immediately.
  - After release, req_valid=1000 is granted with ptr restarted at 0.

Source files
------------

// File: rtl/xor_share_pkg.sv
// rtl/xor_share_pkg.sv - shared types and defaults for the XOR share arbiter
package xor_share_pkg;

  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/xor_share_arbiter_rr.sv
// rtl/xor_share_arbiter_rr.sv - combinational round-robin grant search
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1; gnt is masked by en, gnt_idx/any are not.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  int w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!any && req[w_j]) begin
        any     = 1'b1;
        gnt_idx = IDW'(w_j);
      end
    end
    if (en && any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// rtl/xor_share_arbiter.sv - round-robin sharing of one registered XOR unit among N requesters
// Results are tagged with the owning requester index; only req_ready is combinational.
module xor_share_arbiter
  import xor_share_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_x,
  input  logic [N*WIDTH-1:0]   req_y,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_z,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_z;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_can_accept;
  logic             w_en;
  logic [N-1:0]     w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any;
  logic             w_accept;
  logic             w_load;
  logic             w_clear;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [IDW-1:0]   w_ptr_nxt;

  // Gating by rst_n keeps req_ready low for the whole reset, not just after the first edge.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_HOLD && rsp_ready);
  assign w_en         = w_can_accept && rst_n;
  assign w_accept     = w_en && w_any;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_x       = req_x[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_y       = req_y[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_gnt_idx == IDW'(N-1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_accept)       w_state_nxt = S_HOLD;
        else if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A drain and refill on the same edge is just a load; clear only when nothing replaces the result.
  always_comb begin
    req_ready = w_gnt;
    w_load    = w_accept;
    w_clear   = 1'b0;
    if (r_state == S_HOLD && rsp_ready && !w_accept) w_clear = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_z     <= '0;
      r_rsp_id    <= '0;
    end else if (w_load) begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= 1'b1;
      r_rsp_z     <= w_x ^ w_y;
      r_rsp_id    <= w_gnt_idx;
    end else if (w_clear) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_z     = r_rsp_z;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb/tb_xor_share_arbiter.sv - directed self-checking bench for xor_share_arbiter
module tb_xor_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_z;
  logic [1:0]  rsp_id;
  logic        rsp_ready;

  int n_checks;
  int n_fail;

  xor_share_arbiter #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_xy(input int i, input logic [7:0] x, input logic [7:0] y);
    req_x[i*8 +: 8] = x;
    req_y[i*8 +: 8] = y;
  endtask

  // Drive at negedge, check the combinational grant, then the registered result after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic rr,
                      input logic [3:0] e_gnt, input logic e_valid,
                      input logic [7:0] e_z, input logic [1:0] e_id);
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    #1;
    chk({tag, "_gnt"}, 32'(req_ready), 32'(e_gnt));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(e_valid));
    chk({tag, "_z"}, 32'(rsp_z), 32'(e_z));
    chk({tag, "_id"}, 32'(rsp_id), 32'(e_id));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("rst_gnt", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_z", 32'(rsp_z), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
  endtask

  logic [7:0] rr_z [4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    set_xy(0, 8'hA5, 8'h0F);
    step("single", 4'b0001, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0);

    // Fresh reset so the round-robin walk starts from ptr=0.
    do_reset();
    set_xy(0, 8'h11, 8'h0F);
    set_xy(1, 8'h22, 8'hF0);
    set_xy(2, 8'h33, 8'h55);
    set_xy(3, 8'h44, 8'hAA);
    rr_z[0] = 8'h1E; rr_z[1] = 8'hD2; rr_z[2] = 8'h66; rr_z[3] = 8'hEE;
    for (int k = 0; k < 8; k++) begin
      step($sformatf("rr%0d", k), 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1,
           rr_z[k % 4], 2'(k % 4));
    end

    set_xy(2, 8'hFF, 8'h01);
    step("bp_acc", 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hFE, 2'd2);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("bp_hold%0d", k), 4'b1011, 1'b0, 4'b0000, 1'b1, 8'hFE, 2'd2);
    end
    step("bp_release", 4'b1011, 1'b1, 4'b1000, 1'b1, 8'hEE, 2'd3);

    step("wrap_set", 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hFE, 2'd2);
    step("wrap_skip", 4'b0110, 1'b1, 4'b0010, 1'b1, 8'hD2, 2'd1);
    step("wrap_next", 4'b0110, 1'b1, 4'b0100, 1'b1, 8'hFE, 2'd2);

    step("drain", 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hFE, 2'd2);
    step("idle", 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hFE, 2'd2);

    step("mid_acc", 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h1E, 2'd0);
    step("mid_hold", 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h1E, 2'd0);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1000;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'h0);
    chk("async_z", 32'(rsp_z), 32'h0);
    chk("async_id", 32'(rsp_id), 32'h0);
    chk("async_gnt", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    step("post_ptr0", 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h1E, 2'd0);
    step("post_3", 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hEE, 2'd3);
    step("post_wrap", 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h1E, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
